// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_tgt_state_e;

  localparam logic       ACK_LVL   = 1'b0;
  localparam logic       NACK_LVL  = 1'b1;
  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_target_mem_if.sv
// I2C wire-level bundle: SCL and the SDA wire level in, SDA pull-down enable out.
interface i2c_target_mem_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sampler.sv
// Synchronises SCL/SDA and derives edge and START/STOP pulses.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter (2 clk extra latency).
module i2c_bus_sampler (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f, scl_prev_q, sda_prev_q;

  // Reset to the idle bus level so reset release produces no false edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_maj_q, sda_maj_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_maj_q  <= 1'b1;
      sda_maj_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_maj_q  <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_maj_q  <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_f = scl_maj_q;
  assign sda_f = sda_maj_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign sda_lvl   = sda_f;
  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = ~sda_f & sda_prev_q & scl_f;
  assign stop_det  = sda_f & ~sda_prev_q & scl_f;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a pointer-addressed register file (write/read with auto-increment).
// Optional glitch filtering via I2C_TARGET_GLITCH_FILTER_EN, implemented in i2c_bus_sampler.
module i2c_target_mem
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1001100,
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTRW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_target_mem_if.slave      bus,
  output logic                 busy,
  output logic                 wr_pulse,
  output logic [PTRW-1:0]      wr_ptr,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 nack_seen
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl),
    .sda       (bus.sda_in),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_e       state_q;
  logic [3:0]           bit_cnt_q;
  logic [DATAWIDTH-1:0] shreg_q;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]      ptr_q, ptr_inc;
  logic                 rw_q, sda_oe_q;

  assign ptr_inc    = ptr_q + PTRW'(1);
  assign bus.sda_oe = sda_oe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_ptr    <= '0;
      wr_data   <= '0;
      nack_seen <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      nack_seen <= 1'b0;
      if (stop_det) begin
        state_q   <= StIdle;
        sda_oe_q  <= 1'b0;
        busy      <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
      end else if (scl_rise) begin
        unique case (state_q)
          StAddr, StPtr, StWdata: begin
            if (bit_cnt_q < BYTE_BITS) begin
              shreg_q   <= {shreg_q[DATAWIDTH-2:0], sda_lvl};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          StRdata: if (bit_cnt_q < BYTE_BITS) bit_cnt_q <= bit_cnt_q + 4'd1;
          StRdataAck: begin
            if (sda_lvl == NACK_LVL) begin
              nack_seen <= 1'b1;
              state_q   <= StIgnore;
            end else begin
              ptr_q     <= ptr_inc;
              shreg_q   <= mem_q[ptr_inc];
              bit_cnt_q <= '0;
              state_q   <= StRdata;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        unique case (state_q)
          StIdle, StIgnore: sda_oe_q <= 1'b0;
          StAddr: begin
            sda_oe_q <= 1'b0;
            if (bit_cnt_q == BYTE_BITS) begin
              if (shreg_q[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                sda_oe_q <= ~ACK_LVL;
                busy     <= 1'b1;
                rw_q     <= shreg_q[0];
                state_q  <= StAddrAck;
              end else begin
                state_q  <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            bit_cnt_q <= '0;
            if (rw_q) begin
              // First read bit goes out on the same edge that ends the address ACK.
              shreg_q  <= mem_q[ptr_q];
              sda_oe_q <= ~mem_q[ptr_q][DATAWIDTH-1];
              state_q  <= StRdata;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= StPtr;
            end
          end
          StPtr: begin
            if (bit_cnt_q == BYTE_BITS) begin
              ptr_q    <= shreg_q[PTRW-1:0];
              sda_oe_q <= ~ACK_LVL;
              state_q  <= StPtrAck;
            end
          end
          StPtrAck, StWdataAck: begin
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= StWdata;
          end
          StWdata: begin
            if (bit_cnt_q == BYTE_BITS) begin
              mem_q[ptr_q] <= shreg_q;
              wr_pulse     <= 1'b1;
              wr_ptr       <= ptr_q;
              wr_data      <= shreg_q;
              ptr_q        <= ptr_inc;
              sda_oe_q     <= ~ACK_LVL;
              state_q      <= StWdataAck;
            end
          end
          StRdata: begin
            if (bit_cnt_q == BYTE_BITS) begin
              sda_oe_q <= 1'b0;
              state_q  <= StRdataAck;
            end else if (bit_cnt_q == 4'd0) begin
              sda_oe_q <= ~shreg_q[DATAWIDTH-1];
            end else begin
              shreg_q  <= shreg_q << 1;
              sda_oe_q <= ~shreg_q[DATAWIDTH-2];
            end
          end
          StRdataAck: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed + randomized bench for i2c_target_mem against an array/pointer reference model.
module tb_i2c_target_mem;

  localparam int Q     = 6;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda_m = 1'b1;
  logic       busy, wr_pulse, nack_seen;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data;

  i2c_target_mem_if bus ();
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_mem #(
    .SLAVE_ADDR (7'h4C),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .wr_pulse  (wr_pulse),
    .wr_ptr    (wr_ptr),
    .wr_data   (wr_data),
    .nack_seen (nack_seen)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem_m [DEPTH];
  int         ptr_m = 0;

  logic [11:0] wr_log [1024];
  int          wr_cnt = 0, nack_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      wr_log[wr_cnt % 1024] <= {wr_ptr, wr_data};
      wr_cnt <= wr_cnt + 1;
    end
    if (nack_seen === 1'b1) nack_cnt <= nack_cnt + 1;
    if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic rd);
    sda_m = b;
    clks(Q);
    bus.scl = 1'b1;
    clks(Q);
    rd = bus.sda_in;
    clks(Q);
    bus.scl = 1'b0;
    clks(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b0;
    clks(Q);
    bus.scl = 1'b0;
    clks(Q);
  endtask

  task automatic rstart_c();
    sda_m = 1'b1;
    clks(Q);
    bus.scl = 1'b1;
    clks(Q);
    start_c();
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    clks(Q);
    bus.scl = 1'b1;
    clks(Q);
    sda_m = 1'b1;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, d);
      v[i] = d;
    end
    bit_cycle(mack, d);
  endtask

  task automatic model_write(input logic [7:0] p, input logic [7:0] data [$]);
    logic ack;
    int   base = wr_cnt;
    start_c();
    send_byte(8'h98, ack);
    check("waddr_ack", ack, 0);
    send_byte(p, ack);
    check("wptr_ack", ack, 0);
    ptr_m = int'(p) % DEPTH;
    foreach (data[k]) begin
      send_byte(data[k], ack);
      check("wdata_ack", ack, 0);
      check("wr_strobe", wr_log[(base + k) % 1024], {4'(ptr_m), data[k]});
      mem_m[ptr_m] = data[k];
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    check("busy_in_txn", busy, 1);
    stop_c();
    check("busy_after_stop", busy, 0);
    check("wr_count", wr_cnt - base, data.size());
  endtask

  task automatic model_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] v;
    int         nb = nack_cnt;
    start_c();
    if (set_ptr) begin
      send_byte(8'h98, ack);
      check("raddr_w_ack", ack, 0);
      send_byte(p, ack);
      check("rptr_ack", ack, 0);
      ptr_m = int'(p) % DEPTH;
      rstart_c();
    end
    send_byte(8'h99, ack);
    check("raddr_r_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, v);
      check("rdata", v, mem_m[ptr_m]);
      if (k < n - 1) ptr_m = (ptr_m + 1) % DEPTH;
    end
    stop_c();
    check("nack_pulse", nack_cnt - nb, 1);
  endtask

  initial begin
    logic [7:0] q [$];
    logic       ack;
    logic       d;
    int         oe0, busy0, wr0;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    bus.scl = 1'b1;
    #2 rst = 1'b0;
    clks(5);
    rst = 1'b1;
    clks(4);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_nack_seen", nack_seen, 0);

    // Single write then read-back through a repeated START, NACK keeps the pointer.
    q = '{8'hA5};
    model_write(8'h03, q);
    model_read(1'b1, 8'h03, 1);
    model_read(1'b0, 8'h00, 1);

    // Foreign address: no ACK, no write, no busy.
    oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt;
    start_c();
    send_byte(8'h90, ack);
    check("mismatch_addr_nack", ack, 1);
    send_byte(8'h11, ack);
    check("mismatch_data_nack", ack, 1);
    stop_c();
    check("mismatch_no_oe", oe_cnt - oe0, 0);
    check("mismatch_no_busy", busy_cnt - busy0, 0);
    check("mismatch_no_write", wr_cnt - wr0, 0);

    // Pointer wrap on write and read.
    q = '{8'h11, 8'h22};
    model_write(8'h0F, q);
    model_read(1'b1, 8'h0F, 2);

    // Randomized bursts; the upper pointer-byte bits are ignored by the target.
    repeat (5) begin
      q = {};
      repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
      model_write(8'($urandom), q);
      model_read(1'($urandom), 8'($urandom), $urandom_range(1, 5));
    end

    // Reset asserted while the target drives the write-data ACK.
    start_c();
    send_byte(8'h98, ack);
    send_byte(8'h05, ack);
    for (int i = 7; i >= 0; i--) bit_cycle(1'($urandom), d);
    check("ack_driven_before_rst", bus.sda_oe, 1);
    rst = 1'b0;
    #1;
    check("rst_async_release", bus.sda_oe, 0);
    check("rst_async_busy", busy, 0);
    clks(3);
    bus.scl = 1'b1;
    sda_m = 1'b1;
    clks(3);
    rst = 1'b1;
    clks(4);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    model_read(1'b0, 8'h00, DEPTH);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // A single-clock SDA dip with SCL high must not register as START.
    oe0 = oe_cnt; busy0 = busy_cnt;
    sda_m = 1'b0;
    clks(1);
    sda_m = 1'b1;
    clks(2 * Q);
    bus.scl = 1'b0;
    clks(Q);
    send_byte(8'h98, ack);
    check("glitch_no_start_ack", ack, 1);
    stop_c();
    check("glitch_no_oe", oe_cnt - oe0, 0);
    check("glitch_no_busy", busy_cnt - busy0, 0);
`endif

    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    model_write(8'($urandom), q);
    model_read(1'b1, 8'($urandom), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
